intersection_phase_controller: RTL

//   Sequences a two-approach intersection: main road (NS) and side street (EW).

---
 rtl/traffic_pkg.sv | 41 ++++
 rtl/phase_timer.sv | 27 ++
 rtl/intersection_phase_controller.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and light codes for the intersection phase controller.
// Phase codes double as the externally visible phase status value.
package traffic_pkg;

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned LIGHT_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5
  } phase_e;

  localparam logic [LIGHT_W-1:0] LIGHT_RED    = 3'b100;
  localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = 3'b010;
  localparam logic [LIGHT_W-1:0] LIGHT_GREEN  = 3'b001;

  typedef struct packed {
    logic [LIGHT_W-1:0] ns;
    logic [LIGHT_W-1:0] ew;
  } heads_t;

  // Unknown phase codes fall through to all-red so a corrupted code can never show a green.
  function automatic heads_t decode_heads(logic [PHASE_W-1:0] ph);
    heads_t h;
    h.ns = LIGHT_RED;
    h.ew = LIGHT_RED;
    case (ph)
      NS_GREEN:  h.ns = LIGHT_GREEN;
      NS_YELLOW: h.ns = LIGHT_YELLOW;
      EW_GREEN:  h.ew = LIGHT_GREEN;
      EW_YELLOW: h.ew = LIGHT_YELLOW;
      default:   h = '{ns: LIGHT_RED, ew: LIGHT_RED};
    endcase
    return h;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Free-running phase timer: cleared synchronously, otherwise counts up by one per cycle.
// Terminal-count decisions are made by the controller.
module phase_timer #(
  parameter int unsigned TIMER_W = 16
) (
  input  logic               clock,
  input  logic               clear_i,
  output logic [TIMER_W-1:0] count_o
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q + TIMER_W'(1);
    if (clear_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/intersection_phase_controller.sv
// Actuated two-approach intersection sequencer (NS main road, EW side street).
// Phase register, exit rules, pedestrian latch and registered light decode.
module intersection_phase_controller
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_MIN    = 100,
  parameter int unsigned GREEN_MAX    = 400,
  parameter int unsigned YELLOW_TIME  = 20,
  parameter int unsigned ALL_RED_TIME = 5,
  parameter int unsigned TIMER_W      = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ew_demand,
  input  logic         ped_req,
  output logic [2:0]   ns_light,
  output logic [2:0]   ew_light,
  output logic         ped_walk,
  output logic [2:0]   phase
);

  localparam logic [63:0] TIMER_SPAN = 64'(1) << TIMER_W;

  generate
    if (!((GREEN_MAX >= GREEN_MIN) && (GREEN_MIN >= 1) &&
          (YELLOW_TIME >= 1) && (ALL_RED_TIME >= 1) &&
          (TIMER_W >= 1) && (TIMER_W < 64) &&
          (64'(GREEN_MAX) < TIMER_SPAN))) begin : g_bad_params
      $error("intersection_phase_controller: illegal timing parameters");
    end
  endgenerate

  localparam logic [TIMER_W-1:0] GMIN_LAST = TIMER_W'(GREEN_MIN - 1);
  localparam logic [TIMER_W-1:0] GMAX_LAST = TIMER_W'(GREEN_MAX - 1);
  localparam logic [TIMER_W-1:0] YEL_LAST  = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] RED_LAST  = TIMER_W'(ALL_RED_TIME - 1);

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;
  logic               ped_pending_q;
  logic               ped_pending_d;
  logic               walk_en_q;
  logic               walk_en_d;
  heads_t             heads_q;
  heads_t             heads_d;
  logic               ped_walk_q;
  logic               ped_walk_d;
  logic [TIMER_W-1:0] timer;
  logic               timer_clear_c;
  logic               entering_ew_c;

  // Timer restarts at zero on the first cycle of every phase and out of reset.
  assign timer_clear_c = reset | (phase_d != phase_q);

  phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clock   (clock),
    .clear_i (timer_clear_c),
    .count_o (timer)
  );

  // Next-phase logic; the forced max-green exit also bounds the timer below wrap.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      NS_GREEN: begin
        if (((timer >= GMIN_LAST) && (ew_demand || ped_pending_q)) || (timer == GMAX_LAST)) begin
          phase_d = NS_YELLOW;
        end
      end
      NS_YELLOW: begin
        if (timer == YEL_LAST) begin
          phase_d = ALL_RED_A;
        end
      end
      ALL_RED_A: begin
        if (timer == RED_LAST) begin
          phase_d = EW_GREEN;
        end
      end
      EW_GREEN: begin
        if (((timer >= GMIN_LAST) && !ew_demand) || (timer == GMAX_LAST)) begin
          phase_d = EW_YELLOW;
        end
      end
      EW_YELLOW: begin
        if (timer == YEL_LAST) begin
          phase_d = ALL_RED_B;
        end
      end
      ALL_RED_B: begin
        if (timer == RED_LAST) begin
          phase_d = NS_GREEN;
        end
      end
      default: phase_d = ALL_RED_B;
    endcase
  end

  // Pedestrian latch: a request arriving on the EW entry edge is served in that green.
  always_comb begin
    entering_ew_c = (phase_d == EW_GREEN) && (phase_q != EW_GREEN);
    ped_pending_d = ped_pending_q | ped_req;
    walk_en_d     = walk_en_q;
    if (entering_ew_c) begin
      walk_en_d     = ped_pending_q | ped_req;
      ped_pending_d = 1'b0;
    end else if (phase_d != EW_GREEN) begin
      walk_en_d = 1'b0;
    end
  end

  // Outputs decoded from the next phase so lights and phase move on the same edge.
  always_comb begin
    heads_d    = decode_heads(phase_d);
    ped_walk_d = (phase_d == EW_GREEN) && walk_en_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q       <= NS_GREEN;
      ped_pending_q <= 1'b0;
      walk_en_q     <= 1'b0;
      heads_q       <= '{ns: LIGHT_GREEN, ew: LIGHT_RED};
      ped_walk_q    <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      ped_pending_q <= ped_pending_d;
      walk_en_q     <= walk_en_d;
      heads_q       <= heads_d;
      ped_walk_q    <= ped_walk_d;
    end
  end

  assign ns_light = heads_q.ns;
  assign ew_light = heads_q.ew;
  assign ped_walk = ped_walk_q;
  assign phase    = phase_q;

endmodule
